i2c_word_master: RTL and testbench
==================================

Name: i2c_word_master

Overview:
- Single-clock I2C write master; the downstream consumer of the camera-sensor config sequencer.
- Accepts one 32-bit word {slave_addr_w, sub_addr, data_hi, data_lo} per GO handshake and emits START, 4 bytes each followed by an ACK slot, then STOP on an open-drain bus.
- Runs on the system clock with an internal quarter-bit tick enable; no derived clocks.
- Reports completion and an accumulated NACK flag.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- I2C_FREQ, 20000, SCL frequency in Hz.
- TICK_DIV, CLK_FREQ/(4*I2C_FREQ), iCLK cycles per quarter-bit; must be >=2.

Ports:
- iCLK  in  1  system clock.
- iRST  in  1  reset; asynchronous, active-high.
- iGO  in  1  transfer request; level, held until oEND seen.
- iDATA  in  32  [31:24] slave addr (R/W=0), [23:16] sub-addr, [15:0] data, MSB first.
- oEND  out  1  transfer complete; level.
- oACK  out  1  1 = at least one byte NACKed in last transfer; 0 = all ACKed.
- oBUSY  out  1  transfer in progress.
- oI2C_SCLK  out  1  SCL, driven push-pull; no clock stretching.
- ioI2C_SDAT  inout  1  SDA, open-drain: drives 0 or high-Z, never 1.

Behaviour:
- Reset, asynchronous: state IDLE, oI2C_SCLK=1, SDA high-Z, oEND=0, oACK=0, oBUSY=0, tick counter=0, bit/byte counters=0.
- Tick: qtick pulses once every TICK_DIV iCLK cycles while not IDLE. The counter clears on GO acceptance. The first qtick occurs TICK_DIV cycles after acceptance.
- IDLE: SCL=1, SDA released. When iGO=1 and oEND=0:
  - latch iDATA into shift_reg;
  - clear oACK; set oBUSY;
  - go to START.
  - iDATA changes after acceptance are ignored.
- START, 4 quarters:
  - q0: SCL=1, SDA=Z.
  - q1: SCL=1, SDA=0 (start condition).
  - q2, q3: SCL=0, SDA=0.
- BIT slot, 4 quarters per bit:
  - q0: SCL=0, present bit (0 drives low, 1 releases).
  - q1: SCL=0, hold.
  - q2: SCL=1.
  - q3: SCL=1.
  - 8 data bits, MSB first, then the ACK slot.
- ACK slot: SDA released throughout. Sample SDA at the q3 qtick; if it reads 1, set oACK (sticky OR).
- A NACK does not abort: all 4 bytes are always sent, then STOP.
- STOP, 4 quarters:
  - q0: SCL=0, SDA=0.
  - q1: SCL=1, SDA=0.
  - q2: SCL=1, SDA=Z (stop condition).
  - q3: SCL=1, SDA=Z.
- DONE: at the final STOP qtick, set oEND=1 and clear oBUSY. Total duration is 4 + 4*9*4 + 4 = 152 quarters, so oEND rises exactly 152*TICK_DIV cycles after acceptance.
- Handshake:
  - oEND stays 1 while iGO=1; no restart while iGO is held.
  - The first cycle iGO=0 is sampled, oEND clears on the next edge; state returns to IDLE.
  - oACK holds its value until the next acceptance.
- iGO deassert mid-transfer: ignored; the transfer completes, and oEND pulses for one cycle if iGO is already low at DONE.
- Reset mid-transfer: bus released immediately (SCL=1, SDA=Z). No STOP is generated. The next GO starts a fresh transfer.
- SDA is sampled through a 2-flop synchronizer. Sample timing is referenced to the q3 qtick, so the sync delay must be < TICK_DIV.

Test Plan:
1. Normal write: CLK_FREQ=400, I2C_FREQ=25 (TICK_DIV=4), ACKing slave model, iDATA=32'hBA20C000.
   - SDA bits at SCL rising edges: 10111010 A 00100000 A 11000000 A 00000000 A.
   - START/STOP observed.
   - oEND rises exactly 608 cycles after acceptance; oACK=0.
2. NACK on byte 3 only, iDATA=32'hBA09_07C0: oACK=1, all 36 bit slots still clocked, STOP issued, oEND=1.
3. No slave (SDA pulled up, never driven): oACK=1; SDA never driven high by the DUT (check for drive-1 on the bus).
4. iDATA changed to 32'hFFFFFFFF after 10 cycles of transfer: emitted bits still match the originally latched 32'hBA20C000.
5. iRST asserted during byte 2:
   - SCL=1, SDA=Z, oBUSY=0, oEND=0 asynchronously.
   - After release, GO with 32'hBA050000 completes normally with oACK=0.
6. Handshake:
   - iGO held 100 cycles past oEND: oEND stays 1, SCL stays 1, no second START.
   - iGO drop: oEND=0 one cycle later.
   - Re-raise iGO: a second full transfer occurs.

Source files
------------

// File: rtl/i2c_word_master_if.sv
// i2c_word_master_if
// Word-level handshake between the config sequencer (master side) and the
// I2C word master (slave side).
//   iGO    : transfer request, level, held until oEND is seen
//   iDATA  : {slave_addr_w, sub_addr, data_hi, data_lo}, sent MSB first
//   oEND   : transfer complete, level
//   oACK   : 1 = at least one byte was NACKed in the last transfer
//   oBUSY  : transfer in progress
interface i2c_word_master_if;
  logic        iGO;
  logic [31:0] iDATA;
  logic        oEND;
  logic        oACK;
  logic        oBUSY;

  modport master (output iGO, output iDATA, input oEND, input oACK, input oBUSY);
  modport slave  (input iGO, input iDATA, output oEND, output oACK, output oBUSY);
endinterface

// File: rtl/i2c_word_master.sv
// i2c_word_master
// Single-clock I2C write master. Each accepted word is sent as
// START, four bytes each followed by an ACK slot, then STOP. Bus timing is
// built from a quarter-bit tick enable; no derived clocks.
// Ports:
//   iCLK       : system clock
//   iRST       : asynchronous active-high reset
//   io_hs      : word handshake (iGO/iDATA in, oEND/oACK/oBUSY out)
//   oI2C_SCLK  : SCL, push-pull, no clock stretching
//   ioI2C_SDAT : SDA, open-drain (drives 0 or releases)
module i2c_word_master #(
  parameter int CLK_FREQ = 50000000,
  parameter int I2C_FREQ = 20000,
  parameter int TICK_DIV = CLK_FREQ / (4 * I2C_FREQ)
) (
  input  logic               iCLK,
  input  logic               iRST,
  i2c_word_master_if.slave   io_hs,
  output logic               oI2C_SCLK,
  inout  wire                ioI2C_SDAT
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BIT   = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_tick, w_tick;
  logic [1:0]    r_q, w_q;
  logic [2:0]    r_bit, w_bit;
  logic [1:0]    r_byte, w_byte;
  logic [31:0]   r_shift, w_shift;
  logic          r_scl, w_scl;
  logic          r_sda_low, w_sda_low;
  logic          r_end, w_end;
  logic          r_ack, w_ack;
  logic          r_busy, w_busy;
  logic          r_sda_s1, r_sda_s2;
  logic          w_qtick;

  assign oI2C_SCLK   = r_scl;
  assign ioI2C_SDAT  = r_sda_low ? 1'b0 : 1'bz;
  assign io_hs.oEND  = r_end;
  assign io_hs.oACK  = r_ack;
  assign io_hs.oBUSY = r_busy;

  // Quarter tick only while a transfer is on the bus.
  assign w_qtick = (r_state != S_IDLE) && (r_state != S_DONE) && (r_tick == TICK_LAST);

  // State, datapath and registered bus/handshake outputs.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state   <= S_IDLE;
      r_tick    <= '0;
      r_q       <= 2'd0;
      r_bit     <= 3'd0;
      r_byte    <= 2'd0;
      r_shift   <= 32'd0;
      r_scl     <= 1'b1;
      r_sda_low <= 1'b0;
      r_end     <= 1'b0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_sda_s1  <= 1'b1;
      r_sda_s2  <= 1'b1;
    end else begin
      r_state   <= w_state;
      r_tick    <= w_tick;
      r_q       <= w_q;
      r_bit     <= w_bit;
      r_byte    <= w_byte;
      r_shift   <= w_shift;
      r_scl     <= w_scl;
      r_sda_low <= w_sda_low;
      r_end     <= w_end;
      r_ack     <= w_ack;
      r_busy    <= w_busy;
      r_sda_s1  <= ioI2C_SDAT;
      r_sda_s2  <= r_sda_s1;
    end
  end

  // Next-state, counters and bus levels for the current quarter.
  always_comb begin
    w_state   = r_state;
    w_tick    = w_qtick ? '0 : r_tick + {{(CW-1){1'b0}}, 1'b1};
    w_q       = r_q;
    w_bit     = r_bit;
    w_byte    = r_byte;
    w_shift   = r_shift;
    w_scl     = 1'b1;
    w_sda_low = 1'b0;
    w_end     = r_end;
    w_ack     = r_ack;
    w_busy    = r_busy;

    case (r_state)
      S_IDLE: begin
        w_tick = '0;
        if (io_hs.iGO && !r_end) begin
          w_shift = io_hs.iDATA;
          w_ack   = 1'b0;
          w_busy  = 1'b1;
          w_q     = 2'd0;
          w_bit   = 3'd0;
          w_byte  = 2'd0;
          w_state = S_START;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_START: begin
        // SDA falls while SCL is high in q1, then SCL drops.
        w_scl     = (r_q < 2'd2);
        w_sda_low = (r_q != 2'd0);
        if (w_qtick) begin
          if (r_q == 2'd3) begin
            w_q     = 2'd0;
            w_state = S_BIT;
          end else begin
            w_q = r_q + 2'd1;
          end
        end else begin
          w_q = r_q;
        end
      end
      S_BIT: begin
        w_scl     = r_q[1];
        w_sda_low = ~r_shift[31];
        if (w_qtick) begin
          if (r_q == 2'd3) begin
            w_q     = 2'd0;
            w_shift = {r_shift[30:0], 1'b0};
            if (r_bit == 3'd7) begin
              w_bit   = 3'd0;
              w_state = S_ACK;
            end else begin
              w_bit = r_bit + 3'd1;
            end
          end else begin
            w_q = r_q + 2'd1;
          end
        end else begin
          w_q = r_q;
        end
      end
      S_ACK: begin
        w_scl = r_q[1];
        if (w_qtick) begin
          if (r_q == 2'd3) begin
            // Sticky: a NACK on any byte stays flagged, transfer continues.
            w_ack = r_ack | r_sda_s2;
            w_q   = 2'd0;
            if (r_byte == 2'd3) begin
              w_byte  = 2'd0;
              w_state = S_STOP;
            end else begin
              w_byte  = r_byte + 2'd1;
              w_state = S_BIT;
            end
          end else begin
            w_q = r_q + 2'd1;
          end
        end else begin
          w_q = r_q;
        end
      end
      S_STOP: begin
        // SDA rises while SCL is high in q2.
        w_scl     = (r_q != 2'd0);
        w_sda_low = (r_q < 2'd2);
        if (w_qtick) begin
          if (r_q == 2'd3) begin
            w_q     = 2'd0;
            w_end   = 1'b1;
            w_busy  = 1'b0;
            w_state = S_DONE;
          end else begin
            w_q = r_q + 2'd1;
          end
        end else begin
          w_q = r_q;
        end
      end
      S_DONE: begin
        w_tick = '0;
        // No restart until the requester drops iGO.
        if (!io_hs.iGO) begin
          w_end   = 1'b0;
          w_state = S_IDLE;
        end else begin
          w_state = S_DONE;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_tick  = '0;
        w_busy  = 1'b0;
        w_end   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_word_master.sv
module tb_i2c_word_master;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  logic scl;
  wire  sda;
  logic slave_low = 1'b0;
  logic [3:0] ack_en = 4'b1111;

  i2c_word_master_if hs();

  i2c_word_master #(.CLK_FREQ(400), .I2C_FREQ(25)) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .io_hs      (hs.slave),
    .oI2C_SCLK  (scl),
    .ioI2C_SDAT (sda)
  );

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  always #5 iCLK = ~iCLK;

  int n_pass = 0;
  int n_total = 0;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int   start_cnt = 0;
  int   stop_cnt = 0;
  int   mon_cnt = 36;
  logic [8:0] mon_sh = 9'd0;
  logic prev_scl = 1'b1;
  logic prev_sda = 1'b1;

  // Bus monitor and slave model, sampled mid-cycle on the falling clock edge.
  always @(negedge iCLK) begin
    logic cs, cd;
    int   idx;
    cs = scl;
    cd = (sda === 1'b0) ? 1'b0 : 1'b1;
    if (prev_scl && cs && prev_sda && !cd) begin
      start_cnt = start_cnt + 1;
      mon_cnt   = 0;
      mon_sh    = 9'd0;
    end
    if (prev_scl && cs && !prev_sda && cd) stop_cnt = stop_cnt + 1;
    if (!prev_scl && cs && mon_cnt < 36) begin
      mon_sh  = {mon_sh[7:0], cd};
      mon_cnt = mon_cnt + 1;
      if (mon_cnt % 9 == 0) got_q.push_back(mon_sh);
    end
    if (prev_scl && !cs) begin
      idx = mon_cnt;
      if (idx < 36 && (idx % 9) == 8 && ack_en[idx / 9]) slave_low = 1'b1;
      else slave_low = 1'b0;
    end
    prev_scl = cs;
    prev_sda = cd;
  end

  function automatic void push_expected(input logic [31:0] d, input logic [3:0] acks);
    for (int b = 0; b < 4; b++) begin
      logic [7:0] byt;
      byt = d[31 - 8*b -: 8];
      exp_q.push_back({byt, ~acks[b]});
    end
  endfunction

  // One full transfer; leaves iGO high and oEND set. chg_at>0 rewrites iDATA at that cycle.
  task automatic run_xfer(input string tag, input logic [31:0] d, input logic [3:0] acks,
                          input int chg_at);
    int n;
    ack_en = acks;
    @(negedge iCLK);
    hs.iDATA = d;
    hs.iGO   = 1'b1;
    push_expected(d, acks);
    @(posedge iCLK);
    #1;
    n_total++;
    if (hs.oBUSY !== 1'b1) $display("FAIL %s busy_after_go: got %b want 1", tag, hs.oBUSY);
    else n_pass++;
    n = 0;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge iCLK);
      #1;
      if (i == chg_at) hs.iDATA = 32'hFFFF_FFFF;
      if (hs.oEND === 1'b1) begin
        n = i;
        break;
      end
    end
    n_total++;
    if (n != 608) $display("FAIL %s end_latency: got %0d want 608", tag, n);
    else n_pass++;
    n_total++;
    if (hs.oBUSY !== 1'b0) $display("FAIL %s busy_at_end: got %b want 0", tag, hs.oBUSY);
    else n_pass++;
    n_total++;
    if (hs.oACK !== ~(&acks)) $display("FAIL %s ack_flag: got %b want %b", tag, hs.oACK, ~(&acks));
    else n_pass++;
    for (int b = 0; b < 4; b++) begin
      logic [8:0] e, g;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h000;
      g = (got_q.size() > 0) ? got_q.pop_front() : 9'h1FF;
      n_total++;
      if (g !== e) $display("FAIL %s byte%0d_bits: got %b want %b", tag, b, g, e);
      else n_pass++;
    end
  endtask

  task automatic drop_go(input string tag);
    @(negedge iCLK);
    hs.iGO = 1'b0;
    @(posedge iCLK);
    #1;
    n_total++;
    if (hs.oEND !== 1'b0) $display("FAIL %s end_clear: got %b want 0", tag, hs.oEND);
    else n_pass++;
  endtask

  task automatic test_reset();
    hs.iGO = 1'b0;
    hs.iDATA = 32'd0;
    iRST = 1'b1;
    repeat (3) @(posedge iCLK);
    #1;
    n_total++; if (scl !== 1'b1) $display("FAIL reset_scl: got %b want 1", scl); else n_pass++;
    n_total++; if (sda !== 1'b1) $display("FAIL reset_sda: got %b want 1", sda); else n_pass++;
    n_total++; if (hs.oEND !== 1'b0) $display("FAIL reset_end: got %b want 0", hs.oEND); else n_pass++;
    n_total++; if (hs.oACK !== 1'b0) $display("FAIL reset_ack: got %b want 0", hs.oACK); else n_pass++;
    n_total++; if (hs.oBUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", hs.oBUSY); else n_pass++;
    @(negedge iCLK);
    iRST = 1'b0;
    repeat (2) @(posedge iCLK);
  endtask

  task automatic test_normal();
    int s0, p0;
    s0 = start_cnt;
    p0 = stop_cnt;
    run_xfer("normal", 32'hBA20_C000, 4'b1111, 0);
    n_total++;
    if (start_cnt - s0 != 1) $display("FAIL normal_start: got %0d want 1", start_cnt - s0);
    else n_pass++;
    n_total++;
    if (stop_cnt - p0 != 1) $display("FAIL normal_stop: got %0d want 1", stop_cnt - p0);
    else n_pass++;
    drop_go("normal");
  endtask

  task automatic test_nack_byte3();
    int p0;
    p0 = stop_cnt;
    run_xfer("nack3", 32'hBA09_07C0, 4'b1011, 0);
    n_total++;
    if (stop_cnt - p0 != 1) $display("FAIL nack3_stop: got %0d want 1", stop_cnt - p0);
    else n_pass++;
    drop_go("nack3");
  endtask

  task automatic test_no_slave();
    run_xfer("noslave", 32'hBA20_C000, 4'b0000, 0);
    drop_go("noslave");
  endtask

  task automatic test_data_change();
    run_xfer("datachg", 32'hBA20_C000, 4'b1111, 10);
    drop_go("datachg");
  endtask

  task automatic test_reset_mid();
    int seen;
    ack_en = 4'b1111;
    @(negedge iCLK);
    hs.iDATA = 32'hBA20_C000;
    hs.iGO   = 1'b1;
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge iCLK);
      if (mon_cnt >= 12 && mon_cnt < 17) begin
        seen = 1;
        break;
      end
    end
    n_total++;
    if (seen != 1) $display("FAIL rstmid_reach_byte2: got %0d want 1", seen);
    else n_pass++;
    #2;
    iRST = 1'b1;
    hs.iGO = 1'b0;
    #1;
    n_total++; if (scl !== 1'b1) $display("FAIL rstmid_scl: got %b want 1", scl); else n_pass++;
    n_total++; if (sda !== 1'b1) $display("FAIL rstmid_sda: got %b want 1", sda); else n_pass++;
    n_total++; if (hs.oBUSY !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", hs.oBUSY); else n_pass++;
    n_total++; if (hs.oEND !== 1'b0) $display("FAIL rstmid_end: got %b want 0", hs.oEND); else n_pass++;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
    repeat (2) @(negedge iCLK);
    exp_q.delete();
    got_q.delete();
    run_xfer("afterrst", 32'hBA05_0000, 4'b1111, 0);
    drop_go("afterrst");
  endtask

  task automatic test_back_to_back();
    int viol, s0;
    run_xfer("hold", 32'h1234_5678, 4'b1111, 0);
    viol = 0;
    s0 = start_cnt;
    for (int i = 0; i < 100; i++) begin
      @(negedge iCLK);
      if (hs.oEND !== 1'b1 || scl !== 1'b1) viol++;
    end
    n_total++;
    if (viol != 0) $display("FAIL hold_end_scl: got %0d bad cycles want 0", viol);
    else n_pass++;
    n_total++;
    if (start_cnt != s0) $display("FAIL hold_no_restart: got %0d starts want 0", start_cnt - s0);
    else n_pass++;
    drop_go("hold");
    run_xfer("second", 32'hA5C3_0F81, 4'b1111, 0);
    drop_go("second");
  endtask

  initial begin
    hs.iGO = 1'b0;
    hs.iDATA = 32'd0;
    test_reset();
    test_normal();
    test_nack_byte3();
    test_no_slave();
    test_data_change();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
